div_share_ctrl: RTL and testbench

Sequencing and arbitration controller for the team's 4-bit unsigned divide function. It shares one iterative restoring-division datapath between two requesters using round-robin arbitration. Each accepted operation runs one quotient bit per clock. Results are returned with the requester ID on a single valid/ready result port. The block replaces per-client combinational dividers where area matters more than latency.

---
 rtl/div_share_pkg.sv | 21 ++
 rtl/div_restore_step.sv | 30 +++
 rtl/div_share_ctrl.sv | 147 ++++++++++++++
 tb/tb_div_share_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_share_pkg.sv
// div_share_pkg: shared types and constants for the shared divider controller.
//   state_e   - controller FSM states
//   req_id_t  - requester identifier (two requesters)
//   DIV_W     - default operand width
//   DBZ_FILL  - fill bit for the divide-by-zero quotient (all ones)
package div_share_pkg;

  localparam int DIV_W = 4;

  // Quotient returned on divide-by-zero is every bit set to this value.
  localparam logic DBZ_FILL = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic req_id_t;

endpackage

// File: rtl/div_restore_step.sv
// div_restore_step: one combinational restoring-division step.
//   i_rem     - partial remainder (W bits)
//   i_quo_msb - dividend bit shifted into the remainder this step
//   i_b       - divisor
//   o_rem     - next partial remainder
//   o_q_bit   - quotient bit produced by this step
//
// The trial value t = {rem, quo_msb} needs W+1 bits, but the partial
// remainder itself is always below the divisor and so always fits in W
// bits; the subtraction is only kept when t >= b, where the true
// difference is also below 2^W, so a W-bit subtract is exact there.
module div_restore_step #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_rem,
  input  logic         i_quo_msb,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_rem,
  output logic         o_q_bit
);

  logic [W:0]   w_t;
  logic [W-1:0] w_sub;

  assign w_t     = {i_rem, i_quo_msb};
  assign w_sub   = w_t[W-1:0] - i_b;
  assign o_q_bit = (w_t >= {1'b0, i_b});
  assign o_rem   = o_q_bit ? w_sub : w_t[W-1:0];

endmodule

// File: rtl/div_share_ctrl.sv
// div_share_ctrl: shares one iterative restoring divider between two
// requesters with round-robin arbitration; one quotient bit per clock.
//   clk, reset              - clock, asynchronous active-low reset
//   reqN_valid/a/b/ready    - requester N operation handshake (N = 0,1)
//   res_valid/res_ready     - result handshake
//   res_q, res_r            - quotient, remainder
//   res_id                  - requester that issued the operation
//   res_dbz                 - divisor was zero
//   busy                    - controller is not idle
module div_share_ctrl
  import div_share_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         req1_ready,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_q,
  output logic [W-1:0] res_r,
  output logic         res_id,
  output logic         res_dbz,
  output logic         busy
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  state_e        r_state, w_state_nxt;
  req_id_t       r_rr_ptr;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_rem;
  logic [W-1:0]  r_quo;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_res_q;
  logic [W-1:0]  r_res_r;
  req_id_t       r_res_id;
  logic          r_res_dbz;

  req_id_t       w_grant;
  logic          w_acc;
  logic [W-1:0]  w_a;
  logic [W-1:0]  w_b;
  logic          w_last;
  logic [W-1:0]  w_step_rem;
  logic          w_q_bit;

  // Round-robin only matters when both ask; a lone requester always wins.
  assign w_grant = (req0_valid && req1_valid) ? r_rr_ptr : req_id_t'(req1_valid);
  assign w_acc   = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign w_a     = w_grant ? req1_a : req0_a;
  assign w_b     = w_grant ? req1_b : req0_b;
  assign w_last  = (r_cnt == CW'(W - 1));

  div_restore_step #(.W(W)) u_step (
    .i_rem     (r_rem),
    .i_quo_msb (r_quo[W-1]),
    .i_b       (r_b),
    .o_rem     (w_step_rem),
    .o_q_bit   (w_q_bit)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_acc) w_state_nxt = (w_b == '0) ? DONE : RUN;
      RUN:  if (w_last) w_state_nxt = DONE;
      DONE: if (res_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs: decoded from state; ready additionally qualified by valid and
  // held low while reset is asserted.
  always_comb begin
    busy       = (r_state != IDLE);
    res_valid  = (r_state == DONE);
    req0_ready = reset && (r_state == IDLE) && req0_valid && (w_grant == 1'b0);
    req1_ready = reset && (r_state == IDLE) && req1_valid && (w_grant == 1'b1);
  end

  // Datapath and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_ptr  <= 1'b0;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_b       <= '0;
      r_res_q   <= '0;
      r_res_r   <= '0;
      r_res_id  <= 1'b0;
      r_res_dbz <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_acc) begin
            r_rr_ptr <= ~w_grant;
            r_res_id <= w_grant;
            r_b      <= w_b;
            r_quo    <= w_a;
            r_rem    <= '0;
            r_cnt    <= '0;
            if (w_b == '0) begin
              r_res_q   <= {W{DBZ_FILL}};
              r_res_r   <= w_a;
              r_res_dbz <= 1'b1;
            end else begin
              r_res_dbz <= 1'b0;
            end
          end
        end
        RUN: begin
          r_rem <= w_step_rem;
          r_quo <= {r_quo[W-2:0], w_q_bit};
          r_cnt <= r_cnt + 1'b1;
          // Capture the finished result on the final step so DONE holds it.
          if (w_last) begin
            r_res_q <= {r_quo[W-2:0], w_q_bit};
            r_res_r <= w_step_rem;
          end
        end
        default: ;
      endcase
    end
  end

  assign res_q   = r_res_q;
  assign res_r   = r_res_r;
  assign res_id  = r_res_id;
  assign res_dbz = r_res_dbz;

endmodule

// File: tb/tb_div_share_ctrl.sv
module tb_div_share_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         req0_ready, req1_ready;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] res_q, res_r;
  logic         res_id, res_dbz, busy;

  int checks = 0;
  int errors = 0;

  div_share_ctrl #(.W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_q      (res_q),
    .res_r      (res_r),
    .res_id     (res_id),
    .res_dbz    (res_dbz),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation from requester id, wait for the result, check it,
  // then consume it.
  task automatic do_op(input logic id, input int a, input int b,
                       input int eq, input int er, input int ed);
    int n;
    if (id) begin req1_valid = 1'b1; req1_a = a[W-1:0]; req1_b = b[W-1:0]; end
    else    begin req0_valid = 1'b1; req0_a = a[W-1:0]; req0_b = b[W-1:0]; end
    #1;
    chk($sformatf("ready id%0d %0d/%0d", id, a, b), id ? req1_ready : req0_ready, 1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    n = 0;
    while (!res_valid && n < 20) begin
      step();
      n++;
    end
    chk($sformatf("latency %0d/%0d", a, b), n, (b == 0) ? 0 : W);
    chk($sformatf("q %0d/%0d", a, b), res_q, eq);
    chk($sformatf("r %0d/%0d", a, b), res_r, er);
    chk($sformatf("id %0d/%0d", a, b), res_id, id);
    chk($sformatf("dbz %0d/%0d", a, b), res_dbz, ed);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("consumed valid", res_valid, 0);
    chk("consumed busy", busy, 0);
  endtask

  int da [10] = '{15, 15, 15, 15, 15,  1, 7, 3, 0, 9};
  int db [10] = '{ 1,  2,  6, 14, 15, 15, 2, 6, 0, 0};
  int dq [10] = '{15,  7,  2,  1,  1,  0, 3, 0, 15, 15};
  int dr [10] = '{ 0,  1,  3,  1,  0,  1, 1, 3, 0, 9};
  int dd [10] = '{ 0,  0,  0,  0,  0,  0, 0, 0, 1, 1};

  initial begin
    int  last_acc, nacc, nres, n;
    logic exp_acc_id, exp_res_id;

    // Reset state, with a requester asking while reset is low
    req0_valid = 1'b1;
    #1;
    chk("rst res_valid", res_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst q", res_q, 0);
    chk("rst r", res_r, 0);
    chk("rst id", res_id, 0);
    chk("rst dbz", res_dbz, 0);
    chk("rst req0_ready", req0_ready, 0);
    req0_valid = 1'b0;
    #21 reset = 1'b1;
    step();

    // Contention: both held valid, results consumed immediately
    req0_a = 4'd5; req0_b = 4'd6;
    req1_a = 4'd7; req1_b = 4'd2;
    req0_valid = 1'b1; req1_valid = 1'b1;
    res_ready = 1'b1;
    last_acc = -1; nacc = 0; nres = 0;
    exp_acc_id = 1'b0; exp_res_id = 1'b0;
    #1;
    for (int cyc = 0; cyc < 32; cyc++) begin
      if (req0_ready || req1_ready) begin
        chk("cont grant1", req1_ready, exp_acc_id);
        chk("cont grant0", req0_ready, !exp_acc_id);
        if (last_acc >= 0) chk("cont spacing", cyc - last_acc, 6);
        last_acc = cyc;
        exp_acc_id = ~exp_acc_id;
        nacc++;
      end
      if (res_valid) begin
        chk("cont res_id", res_id, exp_res_id);
        chk("cont res_q", res_q, exp_res_id ? 3 : 0);
        chk("cont res_r", res_r, exp_res_id ? 1 : 5);
        exp_res_id = ~exp_res_id;
        nres++;
      end
      step();
    end
    chk("cont accepts", nacc, 6);
    chk("cont results", nres, 5);
    req0_valid = 1'b0; req1_valid = 1'b0;
    n = 0;
    while (busy && n < 20) begin step(); n++; end
    chk("cont drained", busy, 0);
    res_ready = 1'b0;

    // Directed sequence from requester 0, including divide by zero
    for (int i = 0; i < 10; i++) do_op(1'b0, da[i], db[i], dq[i], dr[i], dd[i]);

    // Backpressure: DONE held for 10 cycles with a request pending
    req0_valid = 1'b1; req0_a = 4'd15; req0_b = 4'd2;
    #1;
    chk("bp ready0", req0_ready, 1);
    step();
    req0_valid = 1'b0;
    repeat (4) step();
    chk("bp res_valid", res_valid, 1);
    req1_valid = 1'b1; req1_a = 4'd2; req1_b = 4'd7;
    #1;
    for (int i = 0; i < 10; i++) begin
      chk("bp hold valid", res_valid, 1);
      chk("bp hold q", res_q, 7);
      chk("bp hold r", res_r, 1);
      chk("bp hold id", res_id, 0);
      chk("bp hold dbz", res_dbz, 0);
      chk("bp hold ready0", req0_ready, 0);
      chk("bp hold ready1", req1_ready, 0);
      chk("bp hold busy", busy, 1);
      step();
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("bp idle valid", res_valid, 0);
    chk("bp idle busy", busy, 0);
    chk("bp pending ready1", req1_ready, 1);
    step();
    req1_valid = 1'b0;
    chk("bp accepted busy", busy, 1);
    repeat (4) step();
    chk("bp2 valid", res_valid, 1);
    chk("bp2 q", res_q, 0);
    chk("bp2 r", res_r, 2);
    chk("bp2 id", res_id, 1);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;

    // Reset in the middle of RUN
    req0_valid = 1'b1; req0_a = 4'd15; req0_b = 4'd6;
    #1;
    chk("mid ready0", req0_ready, 1);
    step();
    step();
    step();
    chk("mid busy before", busy, 1);
    reset = 1'b0;
    #1;
    chk("mid res_valid", res_valid, 0);
    chk("mid busy", busy, 0);
    chk("mid q", res_q, 0);
    chk("mid r", res_r, 0);
    chk("mid id", res_id, 0);
    chk("mid dbz", res_dbz, 0);
    chk("mid ready0", req0_ready, 0);
    step();
    step();
    reset = 1'b1;
    req1_valid = 1'b1; req1_a = 4'd2; req1_b = 4'd7;
    #1;
    chk("mid rr ready0", req0_ready, 1);
    chk("mid rr ready1", req1_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("mid no result", res_valid, 0);
    end
    do_op(1'b1, 2, 7, 0, 2, 0);

    // Every operand pair, alternating requester
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        do_op(1'(a + b), a, b, (b == 0) ? 15 : a / b, (b == 0) ? a : a % b, (b == 0) ? 1 : 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
